// File: rtl/mac_pkg.sv
// Shared constants and types for the parametrised MAC datapath.
// The stage-1 record is sized for the widest supported product and is zero-extended.
package mac_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_LEN    = 8;

    // Upper bound on 2*DATA_W so the stage-1 record can live in the package.
    localparam int MAX_PROD_W = 64;

    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_PROD_W-1:0] product;
        logic                  valid;
        logic                  last;
    } s1_rec_t;

endpackage

// File: rtl/mac_mult_stage.sv
// Combinational unsigned DATA_W x DATA_W multiplier used by the MAC product stage.
// Kept separate so array or tree implementations can be dropped in later.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] p
);

    assign p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

endmodule

// File: rtl/param_mac_unit.sv
// Pipelined dot-product MAC: product register, accumulator, valid/ready result register.
// Define MAC_SAT_EN to clamp on overflow; otherwise results wrap modulo 2^ACC_W.
module param_mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam int CNT_W  = cnt_width(LEN);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((ACC_W > MAX_PROD_W) ? ACC_W : MAX_PROD_W) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
        $error("param_mac_unit: ACC_W must be at least 2*DATA_W");
    end
    if (LEN < 1) begin : g_len_check
        $error("param_mac_unit: LEN must be at least 1");
    end
    if (PROD_W > MAX_PROD_W) begin : g_prod_w_check
        $error("param_mac_unit: 2*DATA_W exceeds MAX_PROD_W");
    end

    logic              stall;
    logic              accept;
    logic              is_last;
    logic              fire;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] prod;
    s1_rec_t           s1;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic [SUM_W-1:0]  sum;
    logic              sum_ovf;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_next;

    // A held result freezes the whole pipe; clr wins over any new beat.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !clr && !stall;
    assign accept   = in_valid && in_ready;
    assign is_last  = (cnt == LAST_IDX);
    assign fire     = s1.valid && !stall && !clr;

    mac_mult_stage #(
        .DATA_W (DATA_W)
    ) u_mult (
        .a (a),
        .b (b),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= is_last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1 <= '0;
        end else if (!stall) begin
            s1.valid   <= accept;
            s1.last    <= is_last;
            s1.product <= MAX_PROD_W'(prod);
        end
    end

    // Any bit at or above ACC_W in the wide sum means this term overflowed.
    always_comb begin
        sum      = {{(SUM_W-ACC_W){1'b0}}, acc_q} + {{(SUM_W-MAX_PROD_W){1'b0}}, s1.product};
        sum_ovf  = |sum[SUM_W-1:ACC_W];
        ovf_next = ovf_q | sum_ovf;
`ifdef MAC_SAT_EN
        acc_next = sum_ovf ? '1 : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (fire) begin
            if (s1.last) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= acc_next;
                ovf_q <= ovf_next;
            end
        end
    end

    // A completing block reloads the register even while the old result is being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (fire && s1.last) begin
            out_valid <= 1'b1;
            out_acc   <= acc_next;
            out_ovf   <= ovf_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_mac_unit.sv
// Self-checking bench for param_mac_unit: three configurations checked against a dot-product model.
// The model computes each block as a plain integer sum, then wraps or clamps it to ACC_W bits.
module tb_param_mac_unit;

    typedef struct {
        int          u;
        logic [15:0] acc;
        logic        ovf;
        int          t;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid [3];
    logic [3:0]  a [3];
    logic [3:0]  b [3];
    logic        clr [3];
    logic        out_ready [3];
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        of0, of1, of2;
    logic [15:0] acc0, acc2;
    logic [7:0]  acc1;

    int     cycle    = 0;
    int     checks   = 0;
    int     failures = 0;
    int     last_acc = 0;
    longint msum [3];
    int     mcnt [3];
    res_t   obs [$];
    res_t   expq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    param_mac_unit #(.DATA_W(4), .ACC_W(16), .LEN(4)) u_len4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0), .a(a[0]), .b(b[0]),
        .clr(clr[0]), .out_valid(ov0), .out_ready(out_ready[0]), .out_acc(acc0), .out_ovf(of0));

    param_mac_unit #(.DATA_W(4), .ACC_W(8), .LEN(2)) u_acc8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1), .a(a[1]), .b(b[1]),
        .clr(clr[1]), .out_valid(ov1), .out_ready(out_ready[1]), .out_acc(acc1), .out_ovf(of1));

    param_mac_unit #(.DATA_W(4), .ACC_W(16), .LEN(1)) u_len1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir2), .a(a[2]), .b(b[2]),
        .clr(clr[2]), .out_valid(ov2), .out_ready(out_ready[2]), .out_acc(acc2), .out_ovf(of2));

    function automatic logic f_ready(input int u);
        case (u)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic f_valid(input int u);
        case (u)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic f_ovf(input int u);
        case (u)
            0:       return of0;
            1:       return of1;
            default: return of2;
        endcase
    endfunction

    function automatic logic [15:0] f_acc(input int u);
        case (u)
            0:       return acc0;
            1:       return {8'h00, acc1};
            default: return acc2;
        endcase
    endfunction

    function automatic int len_of(input int u);
        case (u)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int accw_of(input int u);
        return (u == 1) ? 8 : 16;
    endfunction

    task automatic record(input int u);
        res_t r;
        r.u   = u;
        r.acc = f_acc(u);
        r.ovf = f_ovf(u);
        r.t   = cycle;
        obs.push_back(r);
    endtask

    // Every transferred result (valid && ready) is logged for the running scenario.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (f_valid(i) && out_ready[i]) record(i);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            msum[i] = 0;
            mcnt[i] = 0;
        end
        obs.delete();
        expq.delete();
    endtask

    task automatic model_beat(input int u, input int x, input int y);
        res_t   r;
        longint lim;
        msum[u] += longint'(x * y);
        mcnt[u]++;
        if (mcnt[u] == len_of(u)) begin
            lim   = longint'(1) << accw_of(u);
            r.u   = u;
            r.t   = 0;
            r.ovf = (msum[u] >= lim);
`ifdef MAC_SAT_EN
            r.acc = 16'(r.ovf ? lim - 1 : msum[u]);
`else
            r.acc = 16'(msum[u] % lim);
`endif
            expq.push_back(r);
            msum[u] = 0;
            mcnt[u] = 0;
        end
    endtask

    task automatic send(input int u, input logic [3:0] x, input logic [3:0] y);
        bit ok;
        ok = 1'b0;
        in_valid[u] = 1'b1;
        a[u] = x;
        b[u] = y;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge clk);
            ok = f_ready(u);
            if (ok) begin
                last_acc = cycle;
                model_beat(u, int'(x), int'(y));
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout u%0d: in_ready stayed 0 expected 1 within 200 cycles", u);
        end
    endtask

    task automatic drain_wait();
        for (int g = 0; g < 300 && obs.size() < expq.size(); g++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (f_valid(u) !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out_valid u%0d: got %b expected 0", u, f_valid(u));
            end
            checks++;
            if (f_acc(u) !== 16'd0) begin
                failures++;
                $display("[TB] FAIL reset_out_acc u%0d: got %0d expected 0", u, f_acc(u));
            end
            checks++;
            if (f_ovf(u) !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out_ovf u%0d: got %b expected 0", u, f_ovf(u));
            end
            checks++;
            if (f_ready(u) !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_in_ready u%0d: got %b expected 1", u, f_ready(u));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int t_last;
        model_clear();
        out_ready[0] = 1'b1;
        send(0, 4'd3, 4'd5);
        send(0, 4'd15, 4'd15);
        send(0, 4'd1, 4'd1);
        send(0, 4'd0, 4'd7);
        in_valid[0] = 1'b0;
        t_last = last_acc;
        drain_wait();
        checks++;
        if (obs.size() !== 1 || expq.size() !== 1) begin
            failures++;
            $display("[TB] FAIL basic_count: got %0d results expected 1 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i].acc !== expq[i].acc || obs[i].ovf !== expq[i].ovf) begin
                failures++;
                $display("[TB] FAIL basic_result: got acc=%0d ovf=%b expected acc=%0d ovf=%b",
                         obs[i].acc, obs[i].ovf, expq[i].acc, expq[i].ovf);
            end
        end
        if (obs.size() > 0) begin
            checks++;
            if (obs[0].t !== t_last + 2) begin
                failures++;
                $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", obs[0].t, t_last + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        model_clear();
        out_ready[0] = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (i == 3) out_ready[0] = 1'b0;
                    send(0, 4'd2, 4'd3);
                end
                in_valid[0] = 1'b0;
            end
            begin
                for (int g = 0; g < 100 && !ov0; g++) @(negedge clk);
                repeat (3) @(negedge clk);
                checks++;
                if (ov0 !== 1'b1 || acc0 !== 16'd24) begin
                    failures++;
                    $display("[TB] FAIL bp_held: got valid=%b acc=%0d expected valid=1 acc=24", ov0, acc0);
                end
                checks++;
                if (ir0 !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL bp_in_ready: got %b expected 0", ir0);
                end
                @(posedge clk);
                #2;
                out_ready[0] = 1'b1;
            end
        join
        drain_wait();
        checks++;
        if (obs.size() !== 2 || expq.size() !== 2) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d results expected 2 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i].acc !== expq[i].acc || obs[i].ovf !== expq[i].ovf) begin
                failures++;
                $display("[TB] FAIL bp_result%0d: got acc=%0d ovf=%b expected acc=%0d ovf=%b",
                         i, obs[i].acc, obs[i].ovf, expq[i].acc, expq[i].ovf);
            end
        end
    endtask

    task automatic test_overflow();
        model_clear();
        out_ready[1] = 1'b1;
        send(1, 4'd15, 4'd15);
        send(1, 4'd15, 4'd15);
        send(1, 4'd1, 4'd1);
        send(1, 4'd1, 4'd1);
        in_valid[1] = 1'b0;
        drain_wait();
        checks++;
        if (obs.size() !== 2 || expq.size() !== 2) begin
            failures++;
            $display("[TB] FAIL ovf_count: got %0d results expected 2 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i].acc !== expq[i].acc || obs[i].ovf !== expq[i].ovf) begin
                failures++;
                $display("[TB] FAIL ovf_result%0d: got acc=%0d ovf=%b expected acc=%0d ovf=%b",
                         i, obs[i].acc, obs[i].ovf, expq[i].acc, expq[i].ovf);
            end
        end
    endtask

    task automatic test_clr();
        model_clear();
        out_ready[0] = 1'b1;
        send(0, 4'd1, 4'd1);
        send(0, 4'd1, 4'd1);
        in_valid[0] = 1'b0;
        clr[0] = 1'b1;
        msum[0] = 0;
        mcnt[0] = 0;
        @(negedge clk);
        checks++;
        if (ir0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_in_ready: got %b expected 0", ir0);
        end
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 4'd2, 4'd2);
        in_valid[0] = 1'b0;
        drain_wait();
        checks++;
        if (obs.size() !== 1 || expq.size() !== 1) begin
            failures++;
            $display("[TB] FAIL clr_count: got %0d results expected 1 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i].acc !== expq[i].acc || obs[i].ovf !== expq[i].ovf) begin
                failures++;
                $display("[TB] FAIL clr_result: got acc=%0d ovf=%b expected acc=%0d ovf=%b",
                         obs[i].acc, obs[i].ovf, expq[i].acc, expq[i].ovf);
            end
        end
    endtask

    task automatic test_rst_mid();
        model_clear();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 4'd1, 4'd2);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_valid_early: got %b expected 0", ov0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0 || acc0 !== 16'd0 || of0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs: got valid=%b acc=%0d ovf=%b expected 0 0 0", ov0, acc0, of0);
        end
        checks++;
        if (ir0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_in_ready: got %b expected 1", ir0);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (obs.size() !== 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_no_result: got %0d results expected 0", obs.size());
        end
    endtask

    task automatic test_len1();
        model_clear();
        out_ready[2] = 1'b1;
        send(2, 4'd7, 4'd7);
        send(2, 4'd1, 4'd2);
        in_valid[2] = 1'b0;
        drain_wait();
        checks++;
        if (obs.size() !== 2 || expq.size() !== 2) begin
            failures++;
            $display("[TB] FAIL len1_count: got %0d results expected 2 (model %0d)", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            checks++;
            if (obs[i].acc !== expq[i].acc || obs[i].ovf !== expq[i].ovf) begin
                failures++;
                $display("[TB] FAIL len1_result%0d: got acc=%0d ovf=%b expected acc=%0d ovf=%b",
                         i, obs[i].acc, obs[i].ovf, expq[i].acc, expq[i].ovf);
            end
        end
        if (obs.size() == 2) begin
            checks++;
            if (obs[1].t !== obs[0].t + 1) begin
                failures++;
                $display("[TB] FAIL len1_spacing: got cycles %0d,%0d expected consecutive", obs[0].t, obs[1].t);
            end
        end
    endtask

    // Random operands, random input gaps and random backpressure on each configuration.
    task automatic test_random();
        for (int u = 0; u < 3; u++) begin
            bit done;
            int nbeats;
            model_clear();
            done = 1'b0;
            nbeats = 8 * len_of(u);
            fork
                begin
                    for (int i = 0; i < nbeats; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid[u] = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        send(u, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                    end
                    in_valid[u] = 1'b0;
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #2;
                        out_ready[u] = ($urandom_range(0, 1) == 1);
                    end
                end
            join
            out_ready[u] = 1'b1;
            drain_wait();
            checks++;
            if (obs.size() !== expq.size()) begin
                failures++;
                $display("[TB] FAIL rand_count u%0d: got %0d results expected %0d", u, obs.size(), expq.size());
            end
            for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
                checks++;
                if (obs[i].acc !== expq[i].acc || obs[i].ovf !== expq[i].ovf) begin
                    failures++;
                    $display("[TB] FAIL rand_result u%0d #%0d: got acc=%0d ovf=%b expected acc=%0d ovf=%b",
                             u, i, obs[i].acc, obs[i].ovf, expq[i].acc, expq[i].ovf);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            a[i]         = 4'd0;
            b[i]         = 4'd0;
            clr[i]       = 1'b0;
            out_ready[i] = 1'b1;
            msum[i]      = 0;
            mcnt[i]      = 0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_clr();
        test_rst_mid();
        test_len1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
